// File: rtl/gray_fifo_pkg.sv
// Shared helpers for the dual-clock gray-code FIFO: pointer code conversion and
// default geometry.
package gray_fifo_pkg;

   localparam int unsigned ADDR_W_DEF   = 4;
   localparam int unsigned SYNC_DLY_DEF = 2;

   // Callers zero-extend narrower pointers into this word and slice the result.
   localparam int unsigned GRAY_WORD_W = 32;
   typedef logic [GRAY_WORD_W-1:0] gray_word_t;

   function automatic gray_word_t bin2gray(input gray_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic gray_word_t gray2bin(input gray_word_t gray);
      gray_word_t bin;
      bin[GRAY_WORD_W-1] = gray[GRAY_WORD_W-1];
      for (int i = GRAY_WORD_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/wr_ptr_ctrl_sync.sv
// Multi-flop synchronizer with a configurable reset value. Used for the gray read
// pointer and for the active-low write request.
module wr_ptr_ctrl_sync #(
   parameter int unsigned     WIDTH   = 1,
   parameter int unsigned     STAGES  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= RST_VAL;
         end
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-side controller of the dual-clock gray FIFO: issues RAM writes, exports a
// gray write pointer and reports level/full/almost_full. Sticky overflow exists
// only when WR_PTR_CTRL_OVF_EN is defined; otherwise overflow is tied low.
module wr_ptr_ctrl
   import gray_fifo_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned SYNC_DLY  = SYNC_DLY_DEF,
   parameter int unsigned AFULL_THR = 12
) (
   input  logic              wr_clk,
   input  logic              rst_,
   input  logic [ADDR_W:0]   rd_ptr_g,
   input  logic              wr_req_,
   input  logic              ovf_clr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W:0]   wr_ptr_g,
   output logic [ADDR_W:0]   wr_level,
   output logic              full,
   output logic              almost_full,
   output logic              overflow
);

   localparam int unsigned PW    = ADDR_W + 1;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [PW-1:0] rd_ptr_g_s;
   logic [PW-1:0] rd_ptr_b;
   logic [PW-1:0] level;
   logic [PW-1:0] ptr_inc;
   logic [PW:0]   level_inflight;
   logic          req_n_s;
   logic          req_active;
   logic          wr_en_d;
   gray_word_t    rd_bin_w;
   gray_word_t    wr_gray_w;

   logic          wr_en_q;
   logic [PW-1:0] wr_ptr_b_q;
   logic [PW-1:0] wr_ptr_g_q;

   wr_ptr_ctrl_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_DLY),
      .RST_VAL('0)
   ) u_rd_ptr_sync (
      .clk_i (wr_clk),
      .rst_ni(rst_),
      .d_i   (rd_ptr_g),
      .q_o   (rd_ptr_g_s)
   );

   wr_ptr_ctrl_sync #(
      .WIDTH  (1),
      .STAGES (SYNC_DLY),
      .RST_VAL(1'b1)
   ) u_req_sync (
      .clk_i (wr_clk),
      .rst_ni(rst_),
      .d_i   (wr_req_),
      .q_o   (req_n_s)
   );

   assign rd_bin_w   = gray2bin(gray_word_t'(rd_ptr_g_s));
   assign rd_ptr_b   = rd_bin_w[PW-1:0];
   assign req_active = ~req_n_s;

   // The wrap bit makes the modular difference reach DEPTH exactly when full.
   assign level       = wr_ptr_b_q - rd_ptr_b;
   assign full        = (level == PW'(DEPTH));
   assign almost_full = (level >= PW'(AFULL_THR));

   // Count the write already in flight so a DEPTH-1 level cannot overfill.
   assign level_inflight = {1'b0, level} + {{PW{1'b0}}, wr_en_q};
   assign wr_en_d        = req_active && (level_inflight < (PW+1)'(DEPTH));

   assign ptr_inc   = wr_ptr_b_q + PW'(1);
   assign wr_gray_w = bin2gray(gray_word_t'(ptr_inc));

`ifdef WR_PTR_CTRL_OVF_EN
   logic overflow_q;
`endif

   always_ff @(posedge wr_clk or negedge rst_) begin
      if (!rst_) begin
         wr_en_q    <= 1'b0;
         wr_ptr_b_q <= '0;
         wr_ptr_g_q <= '0;
`ifdef WR_PTR_CTRL_OVF_EN
         overflow_q <= 1'b0;
`endif
      end else begin
         wr_en_q <= wr_en_d;
         if (wr_en_q) begin
            wr_ptr_b_q <= ptr_inc;
            wr_ptr_g_q <= wr_gray_w[PW-1:0];
         end
`ifdef WR_PTR_CTRL_OVF_EN
         // Set has priority over a coincident clear.
         if (req_active && full && !wr_en_q) begin
            overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            overflow_q <= 1'b0;
         end
`endif
      end
   end

`ifdef WR_PTR_CTRL_OVF_EN
   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{ovf_clr, rd_bin_w[GRAY_WORD_W-1:PW], wr_gray_w[GRAY_WORD_W-1:PW]};

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_ptr_b_q[ADDR_W-1:0];
   assign wr_ptr_g = wr_ptr_g_q;
   assign wr_level = level;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Bench for wr_ptr_ctrl: directed fill/overflow/read/wrap steps, then random traffic,
// all checked against a count-based reference model.
module tb_wr_ptr_ctrl;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned SYNC_DLY  = 2;
   localparam int unsigned AFULL_THR = 12;
   localparam int          DEPTH     = 16;
   localparam int          PMOD      = 32;
`ifdef WR_PTR_CTRL_OVF_EN
   localparam int          OVF_ON    = 1;
`else
   localparam int          OVF_ON    = 0;
`endif

   logic              wr_clk = 1'b0;
   logic              rst_;
   logic [ADDR_W:0]   rd_ptr_g;
   logic              wr_req_;
   logic              ovf_clr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W:0]   wr_ptr_g;
   logic [ADDR_W:0]   wr_level;
   logic              full;
   logic              almost_full;
   logic              overflow;

   wr_ptr_ctrl #(
      .ADDR_W   (ADDR_W),
      .SYNC_DLY (SYNC_DLY),
      .AFULL_THR(AFULL_THR)
   ) dut (
      .wr_clk     (wr_clk),
      .rst_       (rst_),
      .rd_ptr_g   (rd_ptr_g),
      .wr_req_    (wr_req_),
      .ovf_clr    (ovf_clr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_ptr_g   (wr_ptr_g),
      .wr_level   (wr_level),
      .full       (full),
      .almost_full(almost_full),
      .overflow   (overflow)
   );

   always #5 wr_clk = ~wr_clk;

   int tests = 0;
   int fails = 0;

   // Reference model: total writes/reads as plain counts, sync delay as queues.
   int wtot;
   int rtot;
   int wen;
   int ovf;
   int req_q[$];
   int rd_q[$];

   function automatic int gray(input int v);
      return v ^ (v >> 1);
   endfunction

   function automatic int mlevel();
      return (((wtot % PMOD) - rd_q[0]) % PMOD + PMOD) % PMOD;
   endfunction

   task automatic model_reset();
      wtot = 0;
      rtot = 0;
      wen  = 0;
      ovf  = 0;
      req_q.delete();
      rd_q.delete();
      for (int i = 0; i < SYNC_DLY; i++) begin
         req_q.push_back(1);
         rd_q.push_back(0);
      end
   endtask

   task automatic model_edge();
      int lvl;
      int reqa;
      int nwen;
      lvl  = mlevel();
      reqa = (req_q[0] == 0);
      nwen = (reqa != 0 && (lvl + wen) < DEPTH) ? 1 : 0;
      if (OVF_ON != 0) begin
         if (reqa != 0 && lvl == DEPTH && wen == 0) ovf = 1;
         else if (ovf_clr) ovf = 0;
      end
      if (wen != 0) wtot++;
      wen = nwen;
      void'(req_q.pop_front());
      req_q.push_back(int'(wr_req_));
      void'(rd_q.pop_front());
      rd_q.push_back(rtot % PMOD);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int lvl;
      lvl = mlevel();
      chk("wr_en", 32'(wr_en), 32'(wen));
      chk("wr_addr", 32'(wr_addr), 32'(wtot % DEPTH));
      chk("wr_ptr_g", 32'(wr_ptr_g), 32'(gray(wtot % PMOD)));
      chk("wr_level", 32'(wr_level), 32'(lvl));
      chk("full", 32'(full), 32'(lvl == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(lvl >= int'(AFULL_THR)));
      chk("overflow", 32'(overflow), 32'(ovf));
   endtask

   task automatic step();
      @(posedge wr_clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({tag, "_wr_ptr_g"}, 32'(wr_ptr_g), 32'd0);
      chk({tag, "_wr_level"}, 32'(wr_level), 32'd0);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      int nwr;
      int wraps;
      rst_     = 1'b0;
      wr_req_  = 1'b1;
      ovf_clr  = 1'b0;
      rd_ptr_g = '0;
      model_reset();
      #1;
      check_zero("rst_noclk");
      @(posedge wr_clk);
      @(posedge wr_clk);
      #2;
      rst_ = 1'b1;
      repeat (3) step();
      check_zero("idle");

      // Fill: request low right after an edge, first write strobe after the third edge.
      wr_req_ = 1'b0;
      step();
      chk("lat_edge1", 32'(wr_en), 32'd0);
      step();
      chk("lat_edge2", 32'(wr_en), 32'd0);
      step();
      chk("lat_edge3", 32'(wr_en), 32'd1);
      for (int i = 0; i < 40 && mlevel() != DEPTH; i++) step();
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_level", 32'(wr_level), 32'd16);
      chk("fill_ptr_g", 32'(wr_ptr_g), 32'h18);
      chk("fill_afull", 32'(almost_full), 32'd1);
      step();
      chk("fill_no_extra", 32'(wr_en), 32'd0);

      // Overflow set, set-beats-clear, then clear once the request is gone.
      chk("ovf_set", 32'(overflow), 32'(OVF_ON));
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_set_wins", 32'(overflow), 32'(OVF_ON));
      wr_req_ = 1'b1;
      repeat (3) step();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);

      // Reader frees three slots; exactly three more writes follow.
      rtot     = 3;
      rd_ptr_g = (ADDR_W + 1)'(gray(3));
      wr_req_  = 1'b0;
      step();
      step();
      chk("rd_level13", 32'(wr_level), 32'd13);
      chk("rd_notfull", 32'(full), 32'd0);
      nwr = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (wr_en) nwr++;
      end
      chk("rd_three_writes", 32'(nwr), 32'd3);
      chk("rd_full_again", 32'(full), 32'd1);
      chk("rd_addr_after", 32'(wr_addr), 32'd3);

      // Random traffic across many pointer wraps.
      wr_req_ = 1'b1;
      repeat (3) step();
      wraps = 0;
      for (int i = 0; i < 800; i++) begin
         wr_req_ = ($urandom_range(0, 3) == 0);
         ovf_clr = ($urandom_range(0, 7) == 0);
         if (rtot < wtot && $urandom_range(0, 1) == 1) begin
            rtot++;
            rd_ptr_g = (ADDR_W + 1)'(gray(rtot % PMOD));
         end
         if (wen != 0 && (wtot % PMOD) == PMOD - 1) wraps++;
         step();
      end
      chk("rand_wrapped", 32'(wraps > 2), 32'd1);

      // Drain to empty.
      wr_req_ = 1'b1;
      ovf_clr = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (rtot < wtot) begin
            rtot++;
            rd_ptr_g = (ADDR_W + 1)'(gray(rtot % PMOD));
         end
         step();
      end
      chk("drain_empty", 32'(wr_level), 32'd0);
      chk("drain_ptr_match", 32'(wr_ptr_g), 32'(rd_ptr_g));

      // Asynchronous reset mid-cycle with outputs non-zero beforehand.
      ovf_clr = 1'b0;
      wr_req_ = 1'b0;
      repeat (6) step();
      #2;
      rst_ = 1'b0;
      #1;
      model_reset();
      rd_ptr_g = '0;
      check_zero("rst_async");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
